// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb countdown controller.
// Digit widths follow the BCD ranges shown on the MM:SS display.
package bomb_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DEFUSED, EXPLODED} state_t;

    typedef logic [3:0] min_t;
    typedef logic [2:0] tens_t;
    typedef logic [3:0] ones_t;

    localparam tens_t SEC_MAX_TENS = 3'd5;
    localparam ones_t SEC_MAX_ONES = 4'd9;

endpackage

// File: rtl/bomb_countdown_ctrl_if.sv
// Player controls and display/status outputs of the bomb countdown controller.
interface bomb_countdown_ctrl_if;
    import bomb_pkg::*;

    logic  arm;
    logic  defuse;
    min_t  min_q;
    tens_t sec_tens;
    ones_t sec_ones;
    logic  running;
    logic  defused;
    logic  explosion;

    modport master (
        output arm, defuse,
        input  min_q, sec_tens, sec_ones, running, defused, explosion
    );

    modport slave (
        input  arm, defuse,
        output min_q, sec_tens, sec_ones, running, defused, explosion
    );

endinterface

// File: rtl/bomb_tick_gen.sv
// Divides the board clock down to a one-cycle tick every CLK_FREQ enabled cycles.
module bomb_tick_gen #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_FREQ);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_FREQ - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bomb_countdown_ctrl.sv
// Bomb game countdown: FSM plus BCD MM:SS down-counter driven by a 1 Hz tick.
// Ends in EXPLODED at 00:00 or DEFUSED if the player defuses first.
module bomb_countdown_ctrl
    import bomb_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned START_MIN = 5
) (
    input logic                   clk,
    input logic                   reset,
    bomb_countdown_ctrl_if.slave  bus
);

    localparam min_t START_VAL = min_t'(START_MIN);

    state_t state_q, state_d;
    min_t   mins_q, mins_d;
    tens_t  tens_q, tens_d;
    ones_t  ones_q, ones_d;
    logic   tick;

    // Divider only runs in RUN; held clear elsewhere so each arm starts a full second.
    bomb_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != RUN),
        .enable (state_q == RUN),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        mins_d  = mins_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        unique case (state_q)
            IDLE: begin
                if (bus.arm) begin
                    state_d = RUN;
                    mins_d  = START_VAL;
                    tens_d  = '0;
                    ones_d  = '0;
                end
            end
            RUN: begin
                // Defuse takes priority over a coincident tick, freezing the time.
                if (bus.defuse) begin
                    state_d = DEFUSED;
                end else if (tick) begin
                    if (ones_q != '0) begin
                        ones_d = ones_q - 4'd1;
                    end else begin
                        ones_d = SEC_MAX_ONES;
                        if (tens_q != '0) begin
                            tens_d = tens_q - 3'd1;
                        end else begin
                            tens_d = SEC_MAX_TENS;
                            mins_d = mins_q - 4'd1;
                        end
                    end
                    if (mins_d == '0 && tens_d == '0 && ones_d == '0) begin
                        state_d = EXPLODED;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mins_q  <= START_VAL;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            mins_q  <= mins_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign bus.min_q     = mins_q;
    assign bus.sec_tens  = tens_q;
    assign bus.sec_ones  = ones_q;
    assign bus.running   = (state_q == RUN);
    assign bus.defused   = (state_q == DEFUSED);
    assign bus.explosion = (state_q == EXPLODED);

endmodule
